// File: rtl/stream_demux.sv
// stream_demux: steers packets from one valid/ready input stream to one of NUM_OUT
// registered output channels chosen by the first beat's in_sel; out-of-range packets are dropped.
module stream_demux #(
    parameter int NUM_OUT    = 4,
    parameter int DATA_WIDTH = 8,
    localparam int SEL_WIDTH = $clog2(NUM_OUT)
) (
    input  logic                  clk,
    input  logic                  rst_n,
    input  logic [DATA_WIDTH-1:0] in_data,
    input  logic                  in_valid,
    input  logic                  in_last,
    input  logic [SEL_WIDTH-1:0]  in_sel,
    output logic                  in_ready,
    output logic [DATA_WIDTH-1:0] out_data [NUM_OUT-1:0],
    output logic [NUM_OUT-1:0]    out_valid,
    output logic [NUM_OUT-1:0]    out_last,
    input  logic [NUM_OUT-1:0]    out_ready,
    output logic                  err_sel,
    output logic                  busy
);

    typedef enum logic [1:0] {
        ST_IDLE,
        ST_PASS,
        ST_DROP
    } state_e;

    localparam logic [SEL_WIDTH:0] NUM_OUT_W = (SEL_WIDTH + 1)'(NUM_OUT);

    state_e                  state_q, state_d;
    logic [SEL_WIDTH-1:0]    route_q, route_d;
    logic                    err_q, err_d;
    logic [DATA_WIDTH-1:0]   data_q [NUM_OUT-1:0];
    logic [NUM_OUT-1:0]      valid_q;
    logic [NUM_OUT-1:0]      last_q;

    logic [SEL_WIDTH-1:0]    target;
    logic                    sel_in_range;
    logic                    dropping;
    logic                    target_free;
    logic                    accept;

    // NOTE: combinational blocks use blocking '=' with every output given a default first,
    // so each path assigns every signal and no latch is inferred.
    always_comb begin
        sel_in_range = ({1'b0, in_sel} < NUM_OUT_W);
        target       = (state_q == ST_IDLE) ? in_sel : route_q;
        dropping     = (state_q == ST_DROP) || ((state_q == ST_IDLE) && !sel_in_range);
        target_free  = 1'b0;
        for (int k = 0; k < NUM_OUT; k++) begin
            if (target == SEL_WIDTH'(k)) begin
                target_free = !valid_q[k] || out_ready[k];
            end
        end
        // Ready is a function of state, selection and slot occupancy only, never of in_valid.
        in_ready = dropping || target_free;
        accept   = in_valid && in_ready;
    end

    always_comb begin
        state_d = state_q;
        route_d = route_q;
        err_d   = 1'b0;
        if (accept) begin
            case (state_q)
                ST_IDLE: begin
                    route_d = in_sel;
                    err_d   = !sel_in_range;
                    if (!in_last) begin
                        state_d = sel_in_range ? ST_PASS : ST_DROP;
                    end
                end
                default: begin
                    if (in_last) begin
                        state_d = ST_IDLE;
                    end
                end
            endcase
        end
    end

    // NOTE: sequential blocks use non-blocking '<=' so every flop samples pre-edge values.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state_q <= ST_IDLE;
            route_q <= '0;
            err_q   <= 1'b0;
        end else begin
            state_q <= state_d;
            route_q <= route_d;
            err_q   <= err_d;
        end
    end

    // NOTE: the payload slots are plain flops, not a RAM, so clearing them on reset is
    // cheap and keeps out_data at zero while rst_n is low.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            valid_q <= '0;
            last_q  <= '0;
            for (int k = 0; k < NUM_OUT; k++) begin
                data_q[k] <= '0;
            end
        end else begin
            for (int k = 0; k < NUM_OUT; k++) begin
                // A refill wins over a drain, so a slot can hand off and reload in one cycle.
                if (accept && !dropping && (target == SEL_WIDTH'(k))) begin
                    valid_q[k] <= 1'b1;
                    last_q[k]  <= in_last;
                    data_q[k]  <= in_data;
                end else if (out_ready[k]) begin
                    valid_q[k] <= 1'b0;
                end
            end
        end
    end

    assign out_data  = data_q;
    assign out_valid = valid_q;
    assign out_last  = last_q;
    assign err_sel   = err_q;
    assign busy      = (state_q != ST_IDLE);

endmodule

// File: tb/tb_stream_demux.sv
// Self-checking bench for stream_demux: scoreboard of expected beats per channel plus
// directed cycle checks on a 4-channel instance and a 3-channel instance.
module tb_stream_demux;

    localparam int NO = 4;
    localparam int DW = 8;

    logic clk = 1'b0;
    logic rst_n = 1'b0;
    always #5 clk = ~clk;

    logic [DW-1:0] in_data;
    logic          in_valid;
    logic          in_last;
    logic [1:0]    in_sel;
    logic          in_ready;
    logic [DW-1:0] out_data [NO-1:0];
    logic [NO-1:0] out_valid;
    logic [NO-1:0] out_last;
    logic [NO-1:0] out_ready;
    logic          err_sel;
    logic          busy;

    stream_demux #(.NUM_OUT(NO), .DATA_WIDTH(DW)) dut (
        .clk(clk), .rst_n(rst_n),
        .in_data(in_data), .in_valid(in_valid), .in_last(in_last), .in_sel(in_sel),
        .in_ready(in_ready),
        .out_data(out_data), .out_valid(out_valid), .out_last(out_last), .out_ready(out_ready),
        .err_sel(err_sel), .busy(busy)
    );

    logic [DW-1:0] d3_in_data;
    logic          d3_in_valid;
    logic          d3_in_last;
    logic [1:0]    d3_in_sel;
    logic          d3_in_ready;
    logic [DW-1:0] d3_out_data [2:0];
    logic [2:0]    d3_out_valid;
    logic [2:0]    d3_out_last;
    logic [2:0]    d3_out_ready;
    logic          d3_err_sel;
    logic          d3_busy;

    stream_demux #(.NUM_OUT(3), .DATA_WIDTH(DW)) dut3 (
        .clk(clk), .rst_n(rst_n),
        .in_data(d3_in_data), .in_valid(d3_in_valid), .in_last(d3_in_last), .in_sel(d3_in_sel),
        .in_ready(d3_in_ready),
        .out_data(d3_out_data), .out_valid(d3_out_valid), .out_last(d3_out_last),
        .out_ready(d3_out_ready),
        .err_sel(d3_err_sel), .busy(d3_busy)
    );

    int checks = 0;
    int errors = 0;

    task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
        checks++;
        if (got !== exp) begin
            errors++;
            $display("FAIL %s: got 0x%0h expected 0x%0h at %0t", tag, got, exp, $time);
        end
    endtask

    typedef struct packed {
        logic [DW-1:0] data;
        logic          last;
    } beat_t;

    typedef enum {M_IDLE, M_PASS, M_DROP} mstate_e;

    beat_t         exp_q [NO][$];
    mstate_e       m_state = M_IDLE;
    int            m_route = 0;
    logic [NO-1:0] hold_v = '0;
    logic [DW-1:0] hold_d [NO];
    logic [NO-1:0] hold_l = '0;

    task automatic flush_model();
        for (int k = 0; k < NO; k++) exp_q[k].delete();
        m_state = M_IDLE;
        hold_v  = '0;
    endtask

    // Sampled on the falling edge: the handshakes seen here complete at the next rising edge.
    always @(negedge clk) begin : monitor
        beat_t b;
        if (rst_n) begin
            check("err_sel_stray", err_sel, 1'b0);
            for (int k = 0; k < NO; k++) begin
                if (hold_v[k]) begin
                    check("hold_valid", out_valid[k], 1'b1);
                    check("hold_data", out_data[k], hold_d[k]);
                    check("hold_last", out_last[k], hold_l[k]);
                end
                if (out_valid[k] && out_ready[k]) begin
                    if (exp_q[k].size() == 0) begin
                        check("unexpected_beat_on_ch", out_data[k], 32'hDEAD);
                    end else begin
                        b = exp_q[k].pop_front();
                        check("sb_data", out_data[k], b.data);
                        check("sb_last", out_last[k], b.last);
                    end
                end
                hold_v[k] = out_valid[k] && !out_ready[k];
                hold_d[k] = out_data[k];
                hold_l[k] = out_last[k];
            end
            if (in_valid && in_ready) begin
                b.data = in_data;
                b.last = in_last;
                if (m_state == M_IDLE) begin
                    m_route = int'(in_sel);
                    if (m_route < NO) exp_q[m_route].push_back(b);
                    if (!in_last) m_state = (m_route < NO) ? M_PASS : M_DROP;
                end else begin
                    if (m_state == M_PASS) exp_q[m_route].push_back(b);
                    if (in_last) m_state = M_IDLE;
                end
            end
        end
    end

    task automatic step();
        @(posedge clk);
        #1;
    endtask

    task automatic send(input logic [DW-1:0] d, input logic [1:0] s, input logic l,
                        output int waits);
        in_valid = 1'b1;
        in_data  = d;
        in_sel   = s;
        in_last  = l;
        waits    = 0;
        @(negedge clk);
        while (!in_ready && waits < 50) begin
            waits++;
            @(negedge clk);
        end
        if (!in_ready) check("in_ready_timeout", in_ready, 1'b1);
        step();
        in_valid = 1'b0;
        in_last  = 1'b0;
    endtask

    initial begin
        #200000;
        $display("FAIL watchdog: simulation did not finish");
        $fatal(1);
    end

    initial begin
        int w;
        int wsum;
        in_valid = 1'b0; in_last = 1'b0; in_sel = '0; in_data = '0; out_ready = '1;
        d3_in_valid = 1'b0; d3_in_last = 1'b0; d3_in_sel = '0; d3_in_data = '0;
        d3_out_ready = '1;

        // Reset state
        #12;
        check("rst_out_valid", out_valid, '0);
        check("rst_out_last", out_last, '0);
        check("rst_err_sel", err_sel, 1'b0);
        check("rst_busy", busy, 1'b0);
        for (int k = 0; k < NO; k++) check("rst_out_data", out_data[k], '0);
        check("rst_d3_out_valid", d3_out_valid, '0);
        @(negedge clk);
        rst_n = 1'b1;
        step();

        // 3-beat packet to channel 2 with all channels ready
        in_valid = 1'b1; in_sel = 2'd2; in_data = 8'h11; in_last = 1'b0;
        @(negedge clk);
        check("p3_ready_b0", in_ready, 1'b1);
        check("p3_busy_c0", busy, 1'b0);
        step();
        in_data = 8'h22;
        @(negedge clk);
        check("p3_valid_c1", out_valid, 4'b0100);
        check("p3_data_c1", out_data[2], 8'h11);
        check("p3_last_c1", out_last[2], 1'b0);
        check("p3_busy_c1", busy, 1'b1);
        step();
        in_data = 8'h33; in_last = 1'b1;
        @(negedge clk);
        check("p3_valid_c2", out_valid, 4'b0100);
        check("p3_data_c2", out_data[2], 8'h22);
        check("p3_busy_c2", busy, 1'b1);
        step();
        in_valid = 1'b0; in_last = 1'b0;
        @(negedge clk);
        check("p3_valid_c3", out_valid, 4'b0100);
        check("p3_data_c3", out_data[2], 8'h33);
        check("p3_last_c3", out_last[2], 1'b1);
        check("p3_busy_c3", busy, 1'b0);
        step();
        @(negedge clk);
        check("p3_valid_c4", out_valid, 4'b0000);
        step();

        // Channel 1 back-pressured for 4 cycles
        out_ready = 4'b1101;
        in_valid = 1'b1; in_sel = 2'd1; in_data = 8'hA1; in_last = 1'b0;
        @(negedge clk);
        check("bp_ready_first", in_ready, 1'b1);
        step();
        in_data = 8'hA2;
        for (int i = 0; i < 4; i++) begin
            @(negedge clk);
            check("bp_ready_stalled", in_ready, 1'b0);
            check("bp_valid_stalled", out_valid[1], 1'b1);
            check("bp_data_stalled", out_data[1], 8'hA1);
            step();
        end
        out_ready = 4'b1111;
        @(negedge clk);
        check("bp_ready_release", in_ready, 1'b1);
        step();
        in_data = 8'hA3; in_last = 1'b1;
        @(negedge clk);
        check("bp_data_a2", out_data[1], 8'hA2);
        step();
        in_valid = 1'b0; in_last = 1'b0;
        @(negedge clk);
        check("bp_data_a3", out_data[1], 8'hA3);
        check("bp_last_a3", out_last[1], 1'b1);
        step();

        // Out-of-range select on the 3-channel instance is dropped
        d3_in_valid = 1'b1; d3_in_sel = 2'd3; d3_in_data = 8'h55; d3_in_last = 1'b0;
        @(negedge clk);
        check("drop_ready_b0", d3_in_ready, 1'b1);
        check("drop_err_c0", d3_err_sel, 1'b0);
        step();
        d3_in_data = 8'h66; d3_in_last = 1'b1;
        @(negedge clk);
        check("drop_err_c1", d3_err_sel, 1'b1);
        check("drop_ready_b1", d3_in_ready, 1'b1);
        check("drop_valid_c1", d3_out_valid, 3'b000);
        check("drop_busy_c1", d3_busy, 1'b1);
        step();
        d3_in_sel = 2'd2; d3_in_data = 8'h77; d3_in_last = 1'b1;
        @(negedge clk);
        check("drop_err_c2", d3_err_sel, 1'b0);
        check("drop_valid_c2", d3_out_valid, 3'b000);
        check("drop_busy_c2", d3_busy, 1'b0);
        check("drop_ready_next", d3_in_ready, 1'b1);
        step();
        d3_in_valid = 1'b0; d3_in_last = 1'b0;
        @(negedge clk);
        check("drop_next_valid", d3_out_valid, 3'b100);
        check("drop_next_data", d3_out_data[2], 8'h77);
        check("drop_next_last", d3_out_last[2], 1'b1);
        check("drop_next_err", d3_err_sel, 1'b0);
        step();

        // in_sel changes mid-packet and must be ignored
        send(8'h01, 2'd0, 1'b0, w);
        send(8'h02, 2'd3, 1'b0, w);
        send(8'h03, 2'd1, 1'b1, w);
        @(negedge clk);
        check("sel_ignored_valid", out_valid, 4'b0001);
        check("sel_ignored_data", out_data[0], 8'h03);
        step();

        // Channel 0 stalled while channel 3 streams at full rate
        out_ready = 4'b1110;
        send(8'hC0, 2'd0, 1'b1, w);
        wsum = 0;
        for (int i = 0; i < 4; i++) begin
            send(8'hB0 + DW'(i), 2'd3, (i == 3), w);
            wsum += w;
        end
        check("full_rate_waits", wsum, 0);
        @(negedge clk);
        check("ch0_held_valid", out_valid[0], 1'b1);
        check("ch0_held_data", out_data[0], 8'hC0);
        out_ready = 4'b1111;
        step();
        step();

        // Reset in the middle of a 4-beat packet
        send(8'hD1, 2'd2, 1'b0, w);
        in_valid = 1'b1; in_data = 8'hD2; in_sel = 2'd2;
        #1;
        rst_n = 1'b0;
        flush_model();
        #1;
        check("async_rst_valid", out_valid, '0);
        check("async_rst_busy", busy, 1'b0);
        in_valid = 1'b0;
        step();
        step();
        @(negedge clk);
        rst_n = 1'b1;
        step();
        send(8'hE1, 2'd1, 1'b1, w);
        check("post_rst_busy_c1", busy, 1'b0);
        @(negedge clk);
        check("post_rst_valid", out_valid, 4'b0010);
        check("post_rst_data", out_data[1], 8'hE1);
        check("post_rst_last", out_last[1], 1'b1);
        check("post_rst_busy", busy, 1'b0);
        step();
        step();

        for (int k = 0; k < NO; k++) check("sb_leftover", exp_q[k].size(), 0);
        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

endmodule
